msrr81: RTL and testbench

MSRR81 -- requirements
Module: msrr81

---
 rtl/msrr81_pkg.sv | 14 +
 rtl/ms_dff.sv | 24 ++
 rtl/msrr81.sv | 47 ++++
 tb/tb_msrr81.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/msrr81_pkg.sv
// Shared definitions for the msrr81 universal shift register: default width
// and the operation-select encoding used on the mode input.
package msrr81_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage : msrr81_pkg

// File: rtl/ms_dff.sv
// One master-slave D flip-flop built from two level-sensitive latches.
// The master follows d while clk is low; the slave follows the master while
// clk is high, so q takes the value d had just before the rising edge.
module ms_dff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic m_q;

  // Master latch: transparent while clk is low, frozen while clk is high.
  // NOTE: these latches are deliberate storage elements, so they use
  // always_latch; a latch appearing in always_comb would be a bug.
  always_latch begin
    if (!clk) m_q <= d;
  end

  // Slave latch: transparent while clk is high, passes the frozen master value.
  always_latch begin
    if (clk) q <= m_q;
  end

endmodule : ms_dff

// File: rtl/msrr81.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// selected by mode, with synchronous active-high reset. Storage is WIDTH
// master-slave flip-flops; next-state selection is done here.
module msrr81
  import msrr81_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sln,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] PO
);

  logic [WIDTH-1:0] po_d;
  logic [WIDTH-1:0] po_q;

  // Next-state selection; reset wins over every mode, including LOAD.
  // NOTE: po_d gets a default first so every path assigns it and no latch
  // is inferred from this combinational block.
  always_comb begin
    po_d = po_q;
    if (rst) begin
      po_d = '0;
    end else begin
      unique case (mode_e'(mode))
        MODE_HOLD: po_d = po_q;
        MODE_SHR:  po_d = {sln[0], po_q[WIDTH-1:1]};
        MODE_SHL:  po_d = {po_q[WIDTH-2:0], sln[0]};
        MODE_LOAD: po_d = sln;
        default:   po_d = po_q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ms_dff u_ms_dff (
      .clk (clk),
      .d   (po_d[i]),
      .q   (po_q[i])
    );
  end

  assign PO = po_q;

endmodule : msrr81

// File: tb/tb_msrr81.sv
// Self-checking bench for msrr81: directed vector table, hand-written
// corner sequences, then a randomised run against an arithmetic model.
module tb_msrr81;

  logic       clk;
  logic       rst;
  logic [7:0] sln;
  logic [1:0] mode;
  logic [7:0] po;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [7:0] sln;
    logic [7:0] exp;
    string      name;
  } vec_t;

  msrr81 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .sln  (sln),
    .mode (mode),
    .PO   (po)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%02h want=%02h", name, act, exp);
    end
  endtask

  // Drive inputs while clk is low, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [1:0] m, input logic [7:0] s);
    @(negedge clk);
    rst  = r;
    mode = m;
    sln  = s;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on the register value.
  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic r,
                                            input logic [1:0] m, input logic [7:0] s);
    int v;
    if (r) return 8'h00;
    v = int'(cur);
    case (m)
      2'd0: return cur;
      2'd1: return 8'((v / 2) + 128 * int'(s[0]));
      2'd2: return 8'(((v * 2) % 256) + int'(s[0]));
      default: return s;
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    logic [7:0] ref_po;

    rst = 1'b0; mode = 2'b00; sln = 8'h00;

    vecs.push_back('{1'b1, 2'b11, 8'hA5, 8'h00, "reset_over_load"});
    vecs.push_back('{1'b0, 2'b11, 8'h5A, 8'h5A, "load_5a"});
    vecs.push_back('{1'b0, 2'b00, 8'hFF, 8'h5A, "hold_1"});
    vecs.push_back('{1'b0, 2'b00, 8'h00, 8'h5A, "hold_2"});
    vecs.push_back('{1'b0, 2'b00, 8'h33, 8'h5A, "hold_3"});
    vecs.push_back('{1'b0, 2'b01, 8'h01, 8'hAD, "shr_in1"});
    vecs.push_back('{1'b0, 2'b01, 8'hFE, 8'h56, "shr_in0"});
    vecs.push_back('{1'b0, 2'b11, 8'h5A, 8'h5A, "reload_5a"});
    vecs.push_back('{1'b0, 2'b10, 8'h01, 8'hB5, "shl_in1"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'h6A, "shl_out_1"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'hD4, "shl_out_2"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'hA8, "shl_out_3"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'h50, "shl_out_4"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'hA0, "shl_out_5"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'h40, "shl_out_6"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'h80, "shl_out_7"});
    vecs.push_back('{1'b0, 2'b10, 8'hFE, 8'h00, "shl_out_8"});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].sln);
      check(vecs[i].name, po, vecs[i].exp);
    end

    // Input glitches while clk is high must not reach PO.
    step(1'b0, 2'b11, 8'h3C);
    check("load_3c", po, 8'h3C);
    @(negedge clk);
    mode = 2'b00; sln = 8'h00;
    @(posedge clk);
    #1;
    check("hold_before_glitch", po, 8'h3C);
    #1 mode = 2'b11; sln = 8'hC3;
    #1 check("glitch_high_load", po, 8'h3C);
    mode = 2'b01; sln = 8'hFF;
    #1 check("glitch_high_shr", po, 8'h3C);
    mode = 2'b00; sln = 8'h00;
    @(posedge clk);
    #1;
    check("after_glitch_edge", po, 8'h3C);

    // Mid-sequence reset during SHL, then resume from zero.
    step(1'b1, 2'b10, 8'hFF);
    check("reset_during_shl", po, 8'h00);
    step(1'b0, 2'b10, 8'h01);
    check("resume_after_reset", po, 8'h01);
    step(1'b0, 2'b01, 8'h01);
    check("resume_shr", po, 8'h80);

    // Randomised run against the model.
    ref_po = po;
    for (int i = 0; i < 1000; i++) begin
      logic       r;
      logic [1:0] m;
      logic [7:0] s;
      r = ($urandom_range(0, 19) == 0);
      m = 2'($urandom_range(0, 3));
      s = 8'($urandom);
      step(r, m, s);
      ref_po = model_next(ref_po, r, m, s);
      check($sformatf("rand_%0d", i), po, ref_po);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_msrr81
